// File: rtl/pump_dispense_controller_pkg.sv
// Shared definitions for the pump dispense controller: state encodings,
// volume width and default timing constants.
package pump_ctrl_pkg;

   localparam int VOL_W                = 16;
   localparam int STEP_ML_DEF          = 50;
   localparam int STALL_CYCLES_DEF     = 3000000;
   localparam int DONE_HOLD_CYCLES_DEF = 2000000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_PUMP   = 3'd2,
      ST_PAUSED = 3'd3,
      ST_DONE   = 3'd4,
      ST_FAULT  = 3'd5
   } pump_state_t;

   // One more counter step would reach or pass the target; widened so the sum cannot wrap.
   function automatic logic near_reached(input logic [VOL_W-1:0] vol,
                                         input logic [VOL_W-1:0] target,
                                         input logic [VOL_W:0]   step);
      return ({1'b0, vol} + step) >= {1'b0, target};
   endfunction

endpackage

// File: rtl/pump_dispense_controller_if.sv
// Operator keypad / volume counter signal bundle for the dispense controller.
// master: keypad, target register and volume counter side; slave: controller.
interface pump_dispense_controller_if;
   import pump_ctrl_pkg::*;

   logic             start;
   logic             stop;
   logic             pause;
   logic             tank_low;
   logic [VOL_W-1:0] target_ml;
   logic [VOL_W-1:0] dispensed_ml;
   logic             relay_auto;
   logic             vol_clear;
   logic             busy;
   logic             done;
   logic             fault;
   logic             near_target;
   logic [2:0]       state_o;

   modport master (
      output start, stop, pause, tank_low, target_ml, dispensed_ml,
      input  relay_auto, vol_clear, busy, done, fault, near_target, state_o
   );

   modport slave (
      input  start, stop, pause, tank_low, target_ml, dispensed_ml,
      output relay_auto, vol_clear, busy, done, fault, near_target, state_o
   );

endinterface

// File: rtl/pump_stall_watchdog.sv
// Stall watchdog for the volume counter. A terminal-count down-counter that
// expires after STALL_CYCLES enabled cycles without a kick. A kick reloads it
// in the same cycle, so the kick cycle itself is the first stalled cycle.
// hold freezes the count; enable low with hold low reloads it.
module pump_stall_watchdog
   import pump_ctrl_pkg::*;
#(
   parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic hold,
   input  logic kick,
   output logic expired
);

   localparam int                CNT_W   = $clog2(STALL_CYCLES) + 1;
   localparam logic [CNT_W-1:0]  TC_LOAD = CNT_W'(STALL_CYCLES - 1);

   logic [CNT_W-1:0] remain;
   logic [CNT_W-1:0] remain_eff;

   // Effective count this cycle: a kick restarts the stall window immediately.
   always_comb begin
      remain_eff = remain;
      if (kick) begin
         remain_eff = TC_LOAD;
      end
   end

   assign expired = enable && (remain_eff == '0);

   // Down-count while enabled, freeze on hold, otherwise sit at the reload value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remain <= TC_LOAD;
      end else if (enable) begin
         if (remain_eff != '0) begin
            remain <= remain_eff - 1'b1;
         end else begin
            remain <= '0;
         end
      end else if (!hold) begin
         remain <= TC_LOAD;
      end
   end

endmodule

// File: rtl/pump_dispense_controller.sv
// Fuel dispense sequencer: clears the volume counter, runs the pump relay
// until the latched target is reached, and stops on operator stop, low tank
// or a stalled volume count. All outputs are registered.
// Build option: define PUMP_PAUSE_EN to enable the pause input and PAUSED state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a start edge
// CLEAR   | one cycle, volume counter cleared, target already latched
// PUMP    | relay on, watching target, stop, tank and stall watchdog
// PAUSED  | relay off, watchdog frozen (PUMP_PAUSE_EN only)
// DONE    | target reached, held for DONE_HOLD_CYCLES then back to IDLE
// FAULT   | low tank or stall; sticky until stop
module pump_dispense_controller
   import pump_ctrl_pkg::*;
#(
   parameter int STEP_ML          = STEP_ML_DEF,
   parameter int STALL_CYCLES     = STALL_CYCLES_DEF,
   parameter int DONE_HOLD_CYCLES = DONE_HOLD_CYCLES_DEF
) (
   input logic                       clk,
   input logic                       rst_n,
   pump_dispense_controller_if.slave bus
);

   localparam int                 HOLD_W    = $clog2(DONE_HOLD_CYCLES) + 1;
   localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(DONE_HOLD_CYCLES - 1);
   localparam logic [VOL_W:0]     STEP_V    = (VOL_W + 1)'(STEP_ML);

   pump_state_t       state;
   pump_state_t       state_nxt;
   logic              start_q;
   logic              start_edge;
   logic [VOL_W-1:0]  target_lat;
   logic [VOL_W-1:0]  vol_prev;
   logic              pump_entry_q;
   logic              load_target;
   logic              target_reached;
   logic              wd_kick;
   logic              wd_expired;
   logic [HOLD_W-1:0] hold_remain;
   logic              hold_done;

   logic relay_q;
   logic vol_clear_q;
   logic busy_q;
   logic done_q;
   logic fault_q;
   logic near_q;

   assign start_edge     = bus.start && !start_q;
   assign target_reached = bus.dispensed_ml >= target_lat;
   assign hold_done      = (hold_remain == '0);
   // Any volume movement, or a fresh entry into PUMP, restarts the stall window.
   assign wd_kick        = (bus.dispensed_ml != vol_prev) || pump_entry_q;

   pump_stall_watchdog #(
      .STALL_CYCLES(STALL_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (state == ST_PUMP),
      .hold   (state == ST_PAUSED),
      .kick   (wd_kick),
      .expired(wd_expired)
   );

   // Next-state decode; stop outranks everything, tank_low outranks target reached.
   always_comb begin
      state_nxt   = state;
      load_target = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_edge && !bus.stop) begin
               if (bus.tank_low) begin
                  state_nxt = ST_FAULT;
               end else begin
                  state_nxt   = ST_CLEAR;
                  load_target = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            if (bus.stop) begin
               state_nxt = ST_IDLE;
            end else if (target_lat == '0) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_PUMP;
            end
         end
         ST_PUMP: begin
            if (bus.stop) begin
               state_nxt = ST_IDLE;
            end else if (bus.tank_low) begin
               state_nxt = ST_FAULT;
            end else if (target_reached) begin
               state_nxt = ST_DONE;
            end else if (wd_expired) begin
               state_nxt = ST_FAULT;
`ifdef PUMP_PAUSE_EN
            end else if (bus.pause) begin
               state_nxt = ST_PAUSED;
`endif
            end
         end
         ST_PAUSED: begin
`ifdef PUMP_PAUSE_EN
            if (bus.stop) begin
               state_nxt = ST_IDLE;
            end else if (bus.tank_low) begin
               state_nxt = ST_FAULT;
            end else if (!bus.pause) begin
               state_nxt = ST_PUMP;
            end
`else
            state_nxt = ST_FAULT;
`endif
         end
         ST_DONE: begin
            if (bus.stop || hold_done) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (bus.stop) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_FAULT;
         end
      endcase
   end

   // State register plus start-edge, volume history and target latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         start_q      <= 1'b0;
         vol_prev     <= '0;
         target_lat   <= '0;
         pump_entry_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         start_q      <= bus.start;
         vol_prev     <= bus.dispensed_ml;
         pump_entry_q <= (state_nxt == ST_PUMP) && (state != ST_PUMP);
         if (load_target) begin
            target_lat <= bus.target_ml;
         end
      end
   end

   // DONE hold timer: loaded on DONE entry, counts down to terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_remain <= '0;
      end else if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
         hold_remain <= HOLD_LOAD;
      end else if ((state == ST_DONE) && !hold_done) begin
         hold_remain <= hold_remain - 1'b1;
      end
   end

   // Registered outputs; relay only stays on across a PUMP-to-PUMP transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         relay_q     <= 1'b0;
         vol_clear_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         near_q      <= 1'b0;
      end else begin
         relay_q     <= (state == ST_PUMP) && (state_nxt == ST_PUMP);
         vol_clear_q <= (state_nxt == ST_CLEAR);
         busy_q      <= (state_nxt == ST_CLEAR) || (state_nxt == ST_PUMP) ||
                        (state_nxt == ST_PAUSED);
         done_q      <= (state_nxt == ST_DONE);
         fault_q     <= (state_nxt == ST_FAULT);
         near_q      <= (state_nxt == ST_PUMP) &&
                        near_reached(bus.dispensed_ml, target_lat, STEP_V);
      end
   end

   assign bus.relay_auto  = relay_q;
   assign bus.vol_clear   = vol_clear_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.fault       = fault_q;
   assign bus.near_target = near_q;
   assign bus.state_o     = state;

endmodule
